// File: rtl/timer_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_bank_pkg
// Description : Shared types and constants for the timer_bank block.
//               This file holds the channel FSM state, the run mode and the
//               prescaler width.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_bank_pkg;

    // Channel lifecycle: stopped, counting, or finished (one-shot only)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Behaviour at terminal count
    typedef enum logic {
        CONTINUOUS = 1'b0,
        ONESHOT    = 1'b1
    } mode_t;

    // Width of the shared tick prescaler and its compare input
    localparam int PRESCALE_W = 16;

endpackage : timer_bank_pkg
`default_nettype wire

// File: rtl/timer_bank_channel.sv
`default_nettype none
// ============================================================================
// Module      : timer_channel
// Description : One programmable period counter of the timer bank.
//               It counts 0..P-1 on ticks and pulses o_tc for one cycle at
//               terminal count. It runs in continuous or one-shot mode.
//               Stop has priority over start, and start has priority over
//               ticking.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_cfg_we,
    input  logic [WIDTH-1:0] i_cfg_period,
    input  logic             i_cfg_oneshot,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    state_t           r_state;
    mode_t            r_mode;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_period_new;
    logic             w_terminal;

    // A programmed period of 0 is stored as 1, so r_period is never 0 and
    // r_period - 1 cannot underflow.
    assign w_period_new = (i_cfg_period == '0) ? c_one : i_cfg_period;

    // The terminal test is ">=" rather than "==". If the period is lowered
    // below the live count, the channel wraps on the next tick instead of
    // running on to 2^WIDTH. The test always uses the period that is
    // already registered. A write that lands on the same edge affects only
    // later ticks.
    assign w_terminal = (r_count >= (r_period - c_one));

    // Channel FSM. The config latch, count and registered outputs all
    // update together here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mode   <= CONTINUOUS;
            r_period <= c_one;
            r_count  <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_tc <= 1'b0;

            // A config write never touches the state or the count. A start
            // on the same edge sees the new settings, because the period
            // and mode are only read on later ticks.
            if (i_cfg_we) begin
                r_period <= w_period_new;
                r_mode   <= mode_t'(i_cfg_oneshot);
            end

            if (i_stop) begin
                // The count is held. In DONE it is already 0.
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else if (i_start) begin
                // A start from any state, including a restart while running.
                // It never produces a tc pulse.
                r_state <= RUN;
                r_count <= '0;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
            end else if ((r_state == RUN) && i_tick) begin
                if (w_terminal) begin
                    r_count <= '0;
                    r_tc    <= 1'b1;
                    if (r_mode == ONESHOT) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end else begin
                    r_count <= r_count + c_one;
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_tc    = r_tc;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule : timer_channel
`default_nettype wire

// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : timer_bank
// Description : Bank of CHANNELS independent programmable period counters.
//               The channels share a config write port. They can also share
//               an optional tick prescaler.
//               Optional feature macro: TIMER_BANK_PRESCALE_EN. When it is
//               defined, the block adds the prescale_in port and a shared
//               prescaler. The prescaler makes a tick every prescale_in+1
//               cycles. When it is undefined, every cycle is a tick.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int CHAN_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)
(
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      cfg_we_in,
    input  logic [CHAN_W-1:0]         cfg_chan_in,
    input  logic [WIDTH-1:0]          cfg_period_in,
    input  logic                      cfg_oneshot_in,
    input  logic [CHANNELS-1:0]       start_in,
    input  logic [CHANNELS-1:0]       stop_in,
`ifdef TIMER_BANK_PRESCALE_EN
    input  logic [PRESCALE_W-1:0]     prescale_in,
`endif
    output logic [CHANNELS*WIDTH-1:0] count_out,
    output logic [CHANNELS-1:0]       tc_out,
    output logic [CHANNELS-1:0]       busy_out,
    output logic [CHANNELS-1:0]       done_out
);

    logic w_tick;

`ifdef TIMER_BANK_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_prescale;

    assign w_tick = (r_prescale == prescale_in);

    // Shared prescaler. It wraps on the tick cycle and is cleared only by reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_prescale <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PRESCALE_W'(1);
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // One channel per index. A channel index with no matching channel
    // matches no decode, so a write to it is dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic w_cfg_hit;

        assign w_cfg_hit = cfg_we_in && (cfg_chan_in == CHAN_W'(i));

        timer_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk           (clk_in),
            .rst           (rst_in),
            .i_tick        (w_tick),
            .i_cfg_we      (w_cfg_hit),
            .i_cfg_period  (cfg_period_in),
            .i_cfg_oneshot (cfg_oneshot_in),
            .i_start       (start_in[i]),
            .i_stop        (stop_in[i]),
            .o_count       (count_out[i*WIDTH +: WIDTH]),
            .o_tc          (tc_out[i]),
            .o_busy        (busy_out[i]),
            .o_done        (done_out[i])
        );
    end

endmodule : timer_bank
`default_nettype wire
